unidade_controle_multiciclo: RTL

- Multi-cycle successor to the single-cycle control unit. One opcode is sequenced over several states, so the memory, switch-input and display-output stages share one datapath.
- Input and output use ready/valid-style waits instead of PC-stall codes.
- Sits between the instruction register and the datapath muxes, ULA, register bank, data memory and I/O stage.

---
 rtl/unidade_controle_multiciclo_pkg.sv | 50 +++++
 rtl/unidade_controle_multiciclo_if.sv | 28 ++
 rtl/unidade_controle_multiciclo.sv | 127 ++++++++++++
 3 files changed

// File: rtl/unidade_controle_multiciclo_pkg.sv
// unidade_controle_multiciclo_pkg: states, opcodes, ULA/PC codes and the ISA decode table
package unidade_controle_pkg;

    typedef enum logic [3:0] {
        INICIO, BUSCA, DECODIFICA, EXECUTA, MEMORIA, ESCRITA, ESPERA_ENTRADA, SAIDA, PARADO
    } estado_t;

    localparam int unsigned OP_NOP = 0,  OP_ADD = 1,  OP_SUB = 2,  OP_AND = 3,  OP_OR = 4;
    localparam int unsigned OP_XOR = 5,  OP_NOR = 6,  OP_SLT = 7,  OP_SLL = 8,  OP_SRL = 9;
    localparam int unsigned OP_ADDI = 10, OP_SUBI = 11, OP_BEQ = 12, OP_BNE = 13, OP_ANDI = 14;
    localparam int unsigned OP_SWR = 15, OP_J = 16, OP_HALT = 18, OP_IN = 19, OP_OUT = 20;
    localparam int unsigned OP_ORI = 22, OP_LW = 23, OP_SW = 24, OP_LWR = 26, OP_JR = 27;
    localparam int unsigned OP_SLTI = 28, OP_NOT = 29, OP_MUL = 30, OP_LI = 31;

    localparam logic [3:0] ULA_ADD = 4'd0, ULA_SUB = 4'd1, ULA_AND = 4'd2, ULA_OR = 4'd3;
    localparam logic [3:0] ULA_XOR = 4'd4, ULA_NOR = 4'd5, ULA_SLT = 4'd6, ULA_SLL = 4'd7;
    localparam logic [3:0] ULA_SRL = 4'd8, ULA_NOT = 4'd9, ULA_MUL = 4'd10, ULA_PASSB = 4'd11;

    localparam logic [2:0] PC_MAIS1 = 3'b000, PC_J = 3'b001, PC_BRANCH = 3'b010, PC_JR = 3'b011;

    typedef struct packed {
        logic [3:0] ula;
        logic       sel_ula;
        logic       sel_end;
    } ula_op_t;

    // Opcodes outside the table (including anything >= 32) decode as an all-zero nop entry
    function automatic ula_op_t ula_op(input logic [31:0] op);
        ula_op_t r;
        r = '0;
        case (op)
            OP_SUB, OP_SUBI, OP_BEQ, OP_BNE: r.ula = ULA_SUB;
            OP_AND, OP_ANDI:                 r.ula = ULA_AND;
            OP_OR, OP_ORI:                   r.ula = ULA_OR;
            OP_XOR:                          r.ula = ULA_XOR;
            OP_NOR:                          r.ula = ULA_NOR;
            OP_SLT, OP_SLTI:                 r.ula = ULA_SLT;
            OP_SLL:                          r.ula = ULA_SLL;
            OP_SRL:                          r.ula = ULA_SRL;
            OP_NOT:                          r.ula = ULA_NOT;
            OP_MUL:                          r.ula = ULA_MUL;
            OP_LI:                           r.ula = ULA_PASSB;
            default:                         r.ula = ULA_ADD;
        endcase
        r.sel_ula = op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI, OP_LI, OP_LW, OP_SW};
        r.sel_end = op inside {[OP_ADD:OP_SRL], OP_NOT, OP_MUL};
        return r;
    endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// unidade_controle_multiciclo_if: IR/datapath/IO signals between control unit (master) and datapath (slave)
interface unidade_controle_multiciclo_if #(
    parameter int OPCODE_WIDTH   = 5,
    parameter int ULA_CTRL_WIDTH = 4
);
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic                      zero, entradaValida, saidaPronta, passo;
    logic                      irEscrita, pcEscrita, regEscrita, memDadosLeitura, memDadosEscrita;
    logic                      selecionaULA, selecionaRegDado, selecionaEndEscrita, selecionaSwitch;
    logic                      estagioEntradaUC, estagioSaidaUC, halt;
    logic [2:0]                pcControle;
    logic [ULA_CTRL_WIDTH-1:0] ulaControle;
    logic [3:0]                estado;

    modport master (
        input  opcode, zero, entradaValida, saidaPronta, passo,
        output irEscrita, pcEscrita, pcControle, regEscrita, memDadosLeitura, memDadosEscrita,
               selecionaULA, selecionaRegDado, selecionaEndEscrita, selecionaSwitch, ulaControle,
               estagioEntradaUC, estagioSaidaUC, halt, estado
    );

    modport slave (
        output opcode, zero, entradaValida, saidaPronta, passo,
        input  irEscrita, pcEscrita, pcControle, regEscrita, memDadosLeitura, memDadosEscrita,
               selecionaULA, selecionaRegDado, selecionaEndEscrita, selecionaSwitch, ulaControle,
               estagioEntradaUC, estagioSaidaUC, halt, estado
    );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: multi-cycle control FSM; PASSO_A_PASSO_EN gates BUSCA on the passo pulse
module unidade_controle_multiciclo
    import unidade_controle_pkg::*;
#(
    parameter int OPCODE_WIDTH   = 5,
    parameter int ULA_CTRL_WIDTH = 4,
    parameter int MEM_LATENCIA   = 1
) (
    input logic                         clock,
    input logic                         reset,
    unidade_controle_multiciclo_if.master uc
);
    localparam int CW = $clog2(MEM_LATENCIA + 1);
    localparam logic [CW-1:0] CNT_CARGA = CW'(MEM_LATENCIA - 1);

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   op;
    ula_op_t       dec;
    logic          is_ula, is_load, is_store;

    assign op       = 32'(uc.opcode[OPCODE_WIDTH-1:0]);
    assign dec      = ula_op(op);
    assign is_ula   = op inside {[OP_ADD:OP_SUBI], OP_ANDI, OP_ORI, [OP_SLTI:OP_LI]};
    assign is_load  = op inside {OP_LW, OP_LWR};
    assign is_store = op inside {OP_SW, OP_SWR};
    assign uc.estado = estado_q;

`ifndef PASSO_A_PASSO_EN
    logic unused_passo;
    assign unused_passo = uc.passo;
`endif

    // State and memory wait counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIO;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state and Moore/Mealy control outputs
    always_comb begin
        estado_d               = estado_q;
        cnt_d                  = cnt_q;
        uc.irEscrita           = 1'b0;
        uc.pcEscrita           = 1'b0;
        uc.pcControle          = PC_MAIS1;
        uc.regEscrita          = 1'b0;
        uc.memDadosLeitura     = 1'b0;
        uc.memDadosEscrita     = 1'b0;
        uc.selecionaULA        = 1'b0;
        uc.selecionaRegDado    = 1'b0;
        uc.selecionaEndEscrita = 1'b0;
        uc.selecionaSwitch     = 1'b0;
        uc.ulaControle         = '0;
        uc.estagioEntradaUC    = 1'b0;
        uc.estagioSaidaUC      = 1'b0;
        uc.halt                = 1'b0;
        if (estado_q inside {DECODIFICA, EXECUTA, MEMORIA, ESCRITA}) begin
            uc.ulaControle         = ULA_CTRL_WIDTH'(dec.ula);
            uc.selecionaULA        = dec.sel_ula;
            uc.selecionaEndEscrita = dec.sel_end;
        end
        case (estado_q)
            INICIO: estado_d = BUSCA;
            BUSCA: begin
`ifdef PASSO_A_PASSO_EN
                uc.irEscrita = uc.passo;
                estado_d     = uc.passo ? DECODIFICA : BUSCA;
`else
                uc.irEscrita = 1'b1;
                estado_d     = DECODIFICA;
`endif
            end
            DECODIFICA: estado_d = op == OP_HALT ? PARADO :
                                   op == OP_IN   ? ESPERA_ENTRADA :
                                   op == OP_OUT  ? SAIDA : EXECUTA;
            EXECUTA: begin
                if (is_load || is_store) begin
                    estado_d = MEMORIA;
                    cnt_d    = CNT_CARGA;
                end else if (is_ula) begin
                    estado_d = ESCRITA;
                end else begin
                    uc.pcEscrita  = 1'b1;
                    uc.pcControle = (op == OP_BEQ && uc.zero) || (op == OP_BNE && !uc.zero) ? PC_BRANCH :
                                    op == OP_J  ? PC_J :
                                    op == OP_JR ? PC_JR : PC_MAIS1;
                    estado_d      = BUSCA;
                end
            end
            MEMORIA: begin
                uc.memDadosLeitura = is_load;
                uc.memDadosEscrita = is_store && cnt_q == CNT_CARGA;
                if (cnt_q == '0) begin
                    uc.pcEscrita = is_store;
                    estado_d     = is_load ? ESCRITA : BUSCA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ESCRITA: begin
                uc.regEscrita       = 1'b1;
                uc.pcEscrita        = 1'b1;
                uc.selecionaRegDado = is_load;
                uc.selecionaSwitch  = op == OP_LWR || op == OP_IN;
                estado_d            = BUSCA;
            end
            ESPERA_ENTRADA: begin
                uc.estagioEntradaUC = 1'b1;
                uc.selecionaSwitch  = 1'b1;
                estado_d            = uc.entradaValida ? ESCRITA : ESPERA_ENTRADA;
            end
            SAIDA: begin
                uc.estagioSaidaUC = 1'b1;
                uc.pcEscrita      = uc.saidaPronta;
                estado_d          = uc.saidaPronta ? BUSCA : SAIDA;
            end
            PARADO: uc.halt = 1'b1;
            default: estado_d = INICIO;
        endcase
    end
endmodule
